// File: rtl/pov_multi.sv
// pov_multi - SPI-loaded, double-buffered bank of NCH two-component vectors.
//
// Frames shifted in over SPI land in per-channel staging registers. They only
// become live (o_vec) on a load_if_ready pulse, so a consumer sampling o_vec
// between frame boundaries never sees a half-updated set of vectors.
//
// Frame (MSB first): CMD[1:0], ADDR[ADDR_W-1:0], payload.
//   CMD 00 single    : X then Y for channel ADDR (2*VW bits)
//   CMD 01 broadcast : X,Y for channel 0 .. NCH-1 (NCH*2*VW bits), ADDR ignored
//   CMD 1x           : rejected
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   i_sclk/i_ss_n/i_mosi  asynchronous SPI pins (mode 0, sampled on SCLK rise)
//   load_if_ready  one-cycle frame-boundary pulse; staged data may go live
//   i_nudge        per-component +/-1 request (bit 2k = ch k X, 2k+1 = ch k Y)
//   i_nudge_dir    0 = decrement, 1 = increment
//   o_vec          live vectors, ch0 X in the MSBs, then ch0 Y, ch1 X, ...
//   o_pending      per-channel "staging holds unloaded data"
//   o_frame_err    one-cycle pulse when a frame header is rejected
module pov_multi #(
  parameter int                  NCH    = 3,
  parameter int                  VW     = 15,
  parameter int                  ADDR_W = 2,
  parameter logic [NCH*2*VW-1:0] INIT   = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_sclk,
  input  logic                i_ss_n,
  input  logic                i_mosi,
  input  logic                load_if_ready,
  input  logic [2*NCH-1:0]    i_nudge,
  input  logic                i_nudge_dir,
  output logic [NCH*2*VW-1:0] o_vec,
  output logic [NCH-1:0]      o_pending,
  output logic                o_frame_err
);

  localparam int H  = 2 + ADDR_W;
  localparam int PW = NCH * 2 * VW;
  localparam int CW = $clog2(H + PW);

  localparam logic [CW-1:0]     HDR_LAST    = CW'(H - 1);
  localparam logic [CW-1:0]     SINGLE_LAST = CW'(H + 2 * VW - 1);
  localparam logic [CW-1:0]     BCAST_LAST  = CW'(H + PW - 1);
  localparam logic [CW-1:0]     CNT_ONE     = CW'(1);
  localparam logic [ADDR_W:0]   NCH_A       = (ADDR_W + 1)'(NCH);

  // Wrapping +/-1 on a two's-complement component.
  function automatic logic [VW-1:0] nudge_f(input logic [VW-1:0] v, input logic up);
    logic [VW-1:0] r;
    if (up) begin
      r = v + VW'(1);
    end else begin
      r = v - VW'(1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- sync
  logic [2:0] sclk_sync_r;
  logic [1:0] ss_sync_r;
  logic [1:0] mosi_sync_r;

  // Bring the asynchronous SPI pins into the clk domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync_r <= 3'b000;
      ss_sync_r   <= 2'b00;
      mosi_sync_r <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], i_sclk};
      ss_sync_r   <= {ss_sync_r[0], i_ss_n};
      mosi_sync_r <= {mosi_sync_r[0], i_mosi};
    end
  end

  logic sclk_rise_s;
  logic ss_high_s;
  logic mosi_s;

  // Rising edge of SCLK seen as stage3=0, stage2=1
  always_comb begin
    sclk_rise_s = (sclk_sync_r[2:1] == 2'b01);
    ss_high_s   = ss_sync_r[1];
    mosi_s      = mosi_sync_r[1];
  end

  // -------------------------------------------------------------- header
  logic [CW-1:0]     cnt_r;
  logic [H-2:0]      hdr_r;
  logic [H-1:0]      hdr_full_s;
  logic [1:0]        hdr_cmd_s;
  logic [ADDR_W-1:0] hdr_addr_s;
  logic              hdr_bcast_s;
  logic              hdr_rej_s;

  // Decode the header as its last bit arrives, so length is known immediately
  always_comb begin
    hdr_full_s  = {hdr_r, mosi_s};
    hdr_cmd_s   = hdr_full_s[H-1:H-2];
    hdr_addr_s  = hdr_full_s[ADDR_W-1:0];
    hdr_bcast_s = 1'b0;
    hdr_rej_s   = 1'b0;
    case (hdr_cmd_s)
      2'b00:   hdr_rej_s   = ({1'b0, hdr_addr_s} >= NCH_A);
      2'b01:   hdr_bcast_s = 1'b1;
      default: hdr_rej_s   = 1'b1;
    endcase
  end

  // --------------------------------------------------------- frame engine
  logic [CW-1:0]     last_r;
  logic              rej_r;
  logic              bcast_r;
  logic [ADDR_W-1:0] addr_r;
  logic [PW-1:0]     shreg_r;
  logic              done_r;
  logic              done_bcast_r;
  logic [ADDR_W-1:0] done_addr_r;
  logic              err_r;

  // Bit counter, header capture, payload shift and end-of-frame flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r        <= '0;
      hdr_r        <= '0;
      last_r       <= SINGLE_LAST;
      rej_r        <= 1'b0;
      bcast_r      <= 1'b0;
      addr_r       <= '0;
      shreg_r      <= '0;
      done_r       <= 1'b0;
      done_bcast_r <= 1'b0;
      done_addr_r  <= '0;
      err_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (ss_high_s) begin
        // Deselect drops any partial frame silently.
        cnt_r <= '0;
      end else if (sclk_rise_s) begin
        if (cnt_r < HDR_LAST) begin
          hdr_r <= hdr_full_s[H-2:0];
          cnt_r <= cnt_r + CNT_ONE;
        end else if (cnt_r == HDR_LAST) begin
          hdr_r   <= hdr_full_s[H-2:0];
          bcast_r <= hdr_bcast_s;
          rej_r   <= hdr_rej_s;
          addr_r  <= hdr_addr_s;
          err_r   <= hdr_rej_s;
          // A rejected frame is clocked through as single length.
          last_r  <= hdr_bcast_s ? BCAST_LAST : SINGLE_LAST;
          cnt_r   <= cnt_r + CNT_ONE;
        end else begin
          shreg_r <= {shreg_r[PW-2:0], mosi_s};
          if (cnt_r == last_r) begin
            // Wrap so another frame may follow under the same /SS.
            cnt_r        <= '0;
            done_r       <= ~rej_r;
            done_bcast_r <= bcast_r;
            done_addr_r  <= addr_r;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
      end
    end
  end

  // ------------------------------------------------------ staging / live
  logic [VW-1:0]  live_x_r  [NCH];
  logic [VW-1:0]  live_y_r  [NCH];
  logic [VW-1:0]  stage_x_r [NCH];
  logic [VW-1:0]  stage_y_r [NCH];
  logic [NCH-1:0] pend_r;

  logic [VW-1:0]  new_x_s [NCH];
  logic [VW-1:0]  new_y_s [NCH];
  logic [NCH-1:0] commit_s;
  logic [NCH-1:0] nudged_s;
  logic [NCH-1:0] pend_next_s;

  // Per-channel commit targets, incoming payload and next pending state
  always_comb begin
    commit_s    = '0;
    nudged_s    = '0;
    pend_next_s = '0;
    for (int k = 0; k < NCH; k++) begin
      new_x_s[k] = '0;
      new_y_s[k] = '0;
      if (done_bcast_r) begin
        new_x_s[k] = shreg_r[(NCH-1-k)*2*VW + VW +: VW];
        new_y_s[k] = shreg_r[(NCH-1-k)*2*VW +: VW];
      end else begin
        new_x_s[k] = shreg_r[2*VW-1:VW];
        new_y_s[k] = shreg_r[VW-1:0];
      end
      commit_s[k] = done_r & (done_bcast_r | (done_addr_r == ADDR_W'(k)));
      nudged_s[k] = load_if_ready & (i_nudge[2*k] | i_nudge[2*k+1]);
      // A nudge discards staging even if a frame commits in the same cycle.
      if (nudged_s[k]) begin
        pend_next_s[k] = 1'b0;
      end else begin
        pend_next_s[k] = (pend_r[k] & ~load_if_ready) | commit_s[k];
      end
    end
  end

  // Write staging, apply go-live and nudges on the frame boundary
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        live_x_r[k]  <= INIT[(NCH-1-k)*2*VW + VW +: VW];
        live_y_r[k]  <= INIT[(NCH-1-k)*2*VW +: VW];
        stage_x_r[k] <= '0;
        stage_y_r[k] <= '0;
      end
      pend_r <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (commit_s[k]) begin
          stage_x_r[k] <= new_x_s[k];
          stage_y_r[k] <= new_y_s[k];
        end
        if (nudged_s[k]) begin
          if (i_nudge[2*k]) begin
            live_x_r[k] <= nudge_f(live_x_r[k], i_nudge_dir);
          end
          if (i_nudge[2*k+1]) begin
            live_y_r[k] <= nudge_f(live_y_r[k], i_nudge_dir);
          end
        end else if (load_if_ready && pend_r[k]) begin
          // Old staging goes live; a same-cycle commit lands behind it.
          live_x_r[k] <= stage_x_r[k];
          live_y_r[k] <= stage_y_r[k];
        end
      end
      pend_r <= pend_next_s;
    end
  end

  // Pack live registers onto the output bus
  always_comb begin
    o_vec = '0;
    for (int k = 0; k < NCH; k++) begin
      o_vec[(NCH-1-k)*2*VW + VW +: VW] = live_x_r[k];
      o_vec[(NCH-1-k)*2*VW +: VW]      = live_y_r[k];
    end
  end

  assign o_pending   = pend_r;
  assign o_frame_err = err_r;

endmodule

// File: doc/pov_multi.md
Name: pov_multi

Overview:
- SPI-loaded, double-buffered bank of NCH two-component vectors. Generalises the single-frame POV register block: channel count and component width are parameters, frames are addressed, and there is per-channel staging.
- Sits between the SPI pins and the raycaster. Vectors go live only on `load_if_ready`, which is the frame boundary, so the renderer never sees a half-updated view.

Parameters:
- NCH, 3, number of vector channels (each has an X and a Y component).
- VW, 15, bits per component. Components are opaque, two's-complement for nudge arithmetic.
- ADDR_W, 2, channel address bits. Must satisfy 2^ADDR_W >= NCH.
- INIT, 0, packed reset value, NCH*2*VW bits. Channel 0 X is in the MSBs, followed by ch0 Y, ch1 X, and so on.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- i_sclk  in  1  SPI clock, asynchronous
- i_ss_n  in  1  SPI select, active-low, asynchronous
- i_mosi  in  1  SPI data, asynchronous
- load_if_ready  in  1  one-cycle pulse: staged data may go live
- i_nudge  in  2*NCH  per-component decrement/increment request, bit 2k = ch k X, bit 2k+1 = ch k Y
- i_nudge_dir  in  1  0 = decrement, 1 = increment
- o_vec  out  NCH*2*VW  live vectors, same packing as INIT
- o_pending  out  NCH  staged data valid per channel
- o_frame_err  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - o_vec=INIT, o_pending=0, o_frame_err=0.
  - Bit counter cleared. Synchroniser shift registers also clear.
  - Reset mid-frame discards the partial frame.
- Synchronisers: 2 flops on MOSI and /SS; 3 flops on SCLK.
- Edge detection: sclk_rise = stage3:stage2 == 01. Bits are sampled only on sclk_rise while synced /SS is low.
- Frame format, MSB first:
  - CMD[1:0], then ADDR[ADDR_W-1:0], then payload.
  - Header length H = 2+ADDR_W.
  - CMD 00 = single: payload 2*VW bits, X then Y, for channel ADDR.
  - CMD 01 = broadcast: payload NCH*2*VW bits, channel 0 first; ADDR is ignored.
  - CMD 1x is invalid.
- Counter:
  - Sized to ceil(log2(H+NCH*2*VW)).
  - Frame end is decided once the header is in. It wraps to 0 after the last bit, so back-to-back frames under one /SS assertion are legal.
  - /SS high clears the counter; the partial frame is dropped with no staging and no error.
- Rejection: invalid CMD, or single with ADDR >= NCH.
  - o_frame_err pulses one cycle after the last header bit's sclk_rise cycle.
  - The rest of that frame's bits are counted as a single-length frame and then discarded.
- Commit timing:
  - The sclk_rise of the last bit is cycle N. At N+1 a done flag is set.
  - At N+2 the staging register(s) are written and the corresponding o_pending bits read 1.
  - A frame arriving while pending is already set overwrites the staging; the last frame wins.
- Go-live on load_if_ready=1, all in that cycle's edge:
  - Every channel with o_pending=1 and no nudge bit set copies staging to live and clears pending.
  - Each nudge-set component becomes live ±1, modulo 2^VW: 0 decremented → 2^VW-1, and 2^VW-1 incremented → 0.
  - Any channel with a nudge bit clears its pending and discards its staging. Other channels load normally.
  - i_nudge is ignored when load_if_ready=0.
- Simultaneous events:
  - If the done-commit cycle equals the load_if_ready cycle, live takes the old staging.
  - The new staging is written, and pending ends 1 for affected channels, except channels nudged in that cycle, which end 0.
- No other path changes o_vec.

Test Plan:
- Defaults (NCH=3, VW=15, INIT ch0=(0x1700,0x1500), others 0): hold reset_n=0 for 3 clk, then release → o_vec=INIT, o_pending=000, no err pulse.
- Single frame CMD00, ADDR01, X=0x1234, Y=0x0042, 34 bits at SCLK=clk/8 → o_pending=010 two clks after the last synced rise. Pulse load_if_ready → ch1=(0x1234,0x0042), ch0/ch2 unchanged, o_pending=000.
- Broadcast (94 bits) then, with /SS held low, single CMD00 ADDR00 X=0x7FFF Y=0x0001 → o_pending=111. After load: ch0=(0x7FFF,0x0001), ch1/ch2 take the broadcast values.
- CMD00 ADDR11 → o_frame_err single pulse, o_pending unchanged. A following valid frame stages correctly, proving recovery.
- Raise /SS after 20 bits, then send a full valid frame → only the second frame staged, no err.
- With ch0 and ch1 pending, pulse load_if_ready with i_nudge=000001 and i_nudge_dir=0, ch0 X=0x0000 → ch0 X=0x7FFF, ch0 Y unchanged, o_pending[0]=0. Ch1 loads its staged values.
